regfile_read_sched: RTL and testbench



---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arb2.sv | 26 ++
 rtl/regfile_read_sched.sv | 117 +++++++++++
 tb/tb_regfile_read_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, state and grant-owner types for regfile_read_sched.
package rf_pkg;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {IDLE, RD_RS1, RD_RS2, RESP, DBG_RD} state_t;
  typedef enum logic {OWN_DEC, OWN_DBG} owner_t;

  // Register x0 always reads as zero regardless of the mux sample.
  function automatic logic [DATA_W-1:0] x0_mask(input logic [ADDR_W-1:0] idx,
                                                input logic [DATA_W-1:0] d);
    return (idx == '0) ? '0 : d;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (decode vs debug) holding last_grant.
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_dec,
  input  logic req_dbg,
  output logic gnt_dec,
  output logic gnt_dbg
);
  owner_t last_grant;

  // On a tie the requester not granted last wins.
  always_comb begin
    gnt_dec = en & req_dec & (~req_dbg | (last_grant == OWN_DBG));
    gnt_dbg = en & req_dbg & ~gnt_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant <= OWN_DBG;
    else if (gnt_dec) last_grant <= OWN_DEC;
    else if (gnt_dbg) last_grant <= OWN_DBG;
  end
endmodule

// File: rtl/regfile_read_sched.sv
// Time-multiplexes the shared register-file read mux select between decode
// operand reads and an optional debug read port (enabled by RF_DBG_PORT_EN).
module regfile_read_sched
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] sl,
  input  logic [DATA_W-1:0] mux_out,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
`ifdef RF_DBG_PORT_EN
  ,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rs1_q, rs2_q;
  logic              idle;
  logic              dec_go;

  assign idle = (state == IDLE);

`ifdef RF_DBG_PORT_EN
  logic [ADDR_W-1:0] dbg_addr_q;
  logic              dbg_go;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (idle),
    .req_dec (dec_valid),
    .req_dbg (dbg_valid),
    .gnt_dec (dec_go),
    .gnt_dbg (dbg_go)
  );

  assign dec_ready = dec_go;
  assign dbg_ready = dbg_go;
`else
  assign dec_ready = idle;
  assign dec_go    = dec_valid & idle;
`endif

  always_comb begin
    state_nxt = state;
    sl        = '0;
    case (state)
      IDLE: begin
        if (dec_go) state_nxt = RD_RS1;
`ifdef RF_DBG_PORT_EN
        else if (dbg_go) state_nxt = DBG_RD;
`endif
      end
      RD_RS1: begin
        sl        = rs1_q;
        state_nxt = RD_RS2;
      end
      RD_RS2: begin
        sl        = rs2_q;
        state_nxt = RESP;
      end
      RESP: if (op_ready) state_nxt = IDLE;
`ifdef RF_DBG_PORT_EN
      DBG_RD: begin
        sl        = dbg_addr_q;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign op_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= state_nxt;
      if (dec_go) begin
        rs1_q <= dec_rs1;
        rs2_q <= dec_rs2;
      end
      if (state == RD_RS1) op_a <= x0_mask(rs1_q, mux_out);
      if (state == RD_RS2) op_b <= x0_mask(rs2_q, mux_out);
    end
  end

`ifdef RF_DBG_PORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_addr_q <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if (dbg_go) dbg_addr_q <= dbg_addr;
      dbg_rvalid <= (state == DBG_RD);
      if (state == DBG_RD) dbg_rdata <= x0_mask(dbg_addr_q, mux_out);
    end
  end
`endif
endmodule

// File: tb/tb_regfile_read_sched.sv
// Scoreboard bench for regfile_read_sched; mux model returns register k as k+1.
module tb_regfile_read_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  sl;
  logic [31:0] mux_out;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
`ifdef RF_DBG_PORT_EN
  logic        dbg_valid, dbg_ready, dbg_rvalid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_rdata;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] exp_op[$];
  logic [31:0] exp_dbg[$];

  always #5 clk = ~clk;
  assign mux_out = 32'(sl) + 32'd1;

  regfile_read_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sl        (sl),
    .mux_out   (mux_out),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b)
`ifdef RF_DBG_PORT_EN
    ,
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_addr  (dbg_addr),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  logic prev_rvalid = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid && op_ready) begin
        if (exp_op.size() == 0) check("op_unexpected", 1, 0);
        else check("op_pair", {op_a, op_b}, exp_op.pop_front());
      end
`ifdef RF_DBG_PORT_EN
      if (dbg_rvalid) begin
        check("dbg_pulse", 64'(prev_rvalid), 0);
        if (exp_dbg.size() == 0) check("dbg_unexpected", 1, 0);
        else check("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg.pop_front()));
      end
      prev_rvalid = dbg_rvalid;
`endif
    end
  end

  task automatic dec_txn(input logic [4:0] r1, input logic [4:0] r2, input int unsigned hold);
    logic [31:0] ea, eb;
    int unsigned n;
    ea = (r1 == 5'd0) ? 32'd0 : 32'(r1) + 32'd1;
    eb = (r2 == 5'd0) ? 32'd0 : 32'(r2) + 32'd1;
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_rs1 = r1; dec_rs2 = r2; op_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dec_ready && n < 20) begin @(negedge clk); n++; end
    check("dec_grant", 64'(dec_ready), 1);
    if (!dec_ready) begin dec_valid = 1'b0; return; end
    exp_op.push_back({ea, eb});
    @(posedge clk); #1;
    dec_valid = 1'b0; dec_rs1 = ~r1; dec_rs2 = ~r2;
    @(negedge clk);
    check("sl_rs1", 64'(sl), 64'(r1));
    check("opv_cyc1", 64'(op_valid), 0);
    @(posedge clk); #1;
    op_ready = (hold == 0);
    @(negedge clk);
    check("sl_rs2", 64'(sl), 64'(r2));
    @(negedge clk);
    check("opv_cyc3", 64'(op_valid), 1);
    check("sl_resp", 64'(sl), 0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      op_ready = (i == hold - 1);
      @(negedge clk);
      check("bp_opv", 64'(op_valid), 1);
      check("bp_ops", {op_a, op_b}, {ea, eb});
      check("bp_dec_ready", 64'(dec_ready), 0);
    end
    @(posedge clk); #1;
    op_ready = 1'b0;
    @(negedge clk);
    check("opv_after", 64'(op_valid), 0);
    check("sl_idle", 64'(sl), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rise;
    rst_n = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; op_ready = 1'b0;
`ifdef RF_DBG_PORT_EN
    dbg_valid = 1'b0; dbg_addr = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_sl", 64'(sl), 0);
    check("rst_opv", 64'(op_valid), 0);
    check("rst_ops", {op_a, op_b}, 0);
`ifdef RF_DBG_PORT_EN
    check("rst_dbg", {31'd0, dbg_rvalid, dbg_rdata}, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    dec_txn(5'd5, 5'd30, 0);
    dec_txn(5'd7, 5'd9, 5);
    dec_txn(5'd0, 5'd0, 0);
    dec_txn(5'd12, 5'd12, 0);

    // Abort a request with reset while in RD_RS2.
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_rs1 = 5'd3; dec_rs2 = 5'd4; op_ready = 1'b1;
    @(negedge clk);
    check("abort_grant", 64'(dec_ready), 1);
    @(posedge clk); #1 dec_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_sl", 64'(sl), 0);
    check("abort_opv", 64'(op_valid), 0);
    check("abort_ops", {op_a, op_b}, 0);
`ifndef RF_DBG_PORT_EN
    check("abort_idle", 64'(dec_ready), 1);
`else
    check("abort_dbg", {31'd0, dbg_rvalid, dbg_rdata}, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    rise = 1'b0;
    repeat (6) begin @(negedge clk); if (op_valid) rise = 1'b1; end
    check("abort_no_opv", 64'(rise), 0);
    op_ready = 1'b0;

`ifdef RF_DBG_PORT_EN
    begin
      logic [2:0] seq;
      int unsigned g, n;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      op_ready = 1'b1;
      dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd30;
      dbg_valid = 1'b1; dbg_addr = 5'd31;
      seq = '0; g = 0; n = 0;
      while (g < 3 && n < 40) begin
        @(negedge clk);
        n++;
        if (dec_ready && dbg_ready) begin
          check("gnt_onehot", 1, 0);
          g = 3;
        end else if (dec_ready) begin
          seq[g] = 1'b0; exp_op.push_back({32'd6, 32'd31}); g++;
        end else if (dbg_ready) begin
          seq[g] = 1'b1; exp_dbg.push_back(32'd32); g++;
        end
      end
      check("arb_count", 64'(g), 3);
      check("arb_seq", 64'(seq), 64'(3'b010));
      @(posedge clk); #1;
      dec_valid = 1'b0; dbg_valid = 1'b0;
      repeat (8) @(negedge clk);
      op_ready = 1'b0;
    end
`endif

    dec_txn(5'd5, 5'd30, 0);
    repeat (4) @(negedge clk);
    check("op_q_empty", 64'(exp_op.size()), 0);
    check("dbg_q_empty", 64'(exp_dbg.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
